// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
// Contents:
//   NUM_REQ  number of requesters sharing the TX FIFO write port
//   state_e  arbiter state (IDLE, BUSY)
package uart_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter giving two byte-stream requesters message-granular
// ownership of a single TX FIFO write port.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_valid/s_last[1:0]   per-requester beat valid and end-of-message
//   s_data0/s_data1       per-requester beat data
//   s_ready[1:0]          per-requester beat accept (combinational)
//   grant[1:0]            registered one-hot owner, 2'b00 when idle
//   fifo_full             downstream FIFO full flag
//   fifo_wr/fifo_wdata    FIFO write strobe and data (combinational)
// Build option:
//   UART_ARB_BURST_LIMIT_EN  also release the grant after MAX_BURST beats
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ-1:0]   s_last,
  input  logic [DATA_BITS-1:0] s_data0,
  input  logic [DATA_BITS-1:0] s_data1,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [DATA_BITS-1:0] fifo_wdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 last_owner_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  logic busy_c;
  logic owner_c;
  logic xfer_c;
  logic end_c;
  logic pick1_c;

  // Index of the current owner; grant is one-hot so bit 1 alone identifies it.
  assign busy_c  = (state_q == BUSY);
  assign owner_c = grant_q[1];
  assign xfer_c  = busy_c & s_valid[owner_c] & ~fifo_full;

  // Tie goes to the requester that did not own the port last.
  assign pick1_c = (s_valid == 2'b11) ? ~last_owner_q : s_valid[1];

  // Saturating beat counter next value.
  assign cnt_d = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + CNT_W'(1);

  // Grant release condition on the current transfer.
`ifdef UART_ARB_BURST_LIMIT_EN
  assign end_c = xfer_c & (s_last[owner_c] | (cnt_d == CNT_W'(MAX_BURST)));
`else
  assign end_c = xfer_c & s_last[owner_c];
`endif

  // Handshake and write-port outputs follow the registered grant directly.
  assign s_ready    = busy_c ? (grant_q & {NUM_REQ{~fifo_full}}) : '0;
  assign fifo_wr    = xfer_c;
  assign fifo_wdata = busy_c ? (owner_c ? s_data1 : s_data0) : '0;
  assign grant      = grant_q;

  // Arbitration FSM with grant, owner history and beat count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid != '0) begin
            state_q <= BUSY;
            grant_q <= pick1_c ? 2'b10 : 2'b01;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (xfer_c) begin
            cnt_q <= cnt_d;
          end
          if (end_c) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= owner_c;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning width of one byte beat.
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per grant when the burst limit is compiled in.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  2  per-requester beat valid, bit i for requester i.
REQ-006 SHALL have port s_last  input  2  per-requester end-of-message marker, qualified by s_valid.
REQ-007 SHALL have ports s_data0 and s_data1  input  DATA_BITS  requester 0 and 1 beat data.
REQ-008 SHALL have port s_ready  output  2  per-requester beat accept.
REQ-009 SHALL have port grant  output  2  one-hot registered owner of the TX FIFO write port; 2'b00 when idle.
REQ-010 SHALL have port fifo_full  input  1  full flag of the downstream TX FIFO.
REQ-011 SHALL have port fifo_wr  output  1  write strobe to the TX FIFO.
REQ-012 SHALL have port fifo_wdata  output  DATA_BITS  write data to the TX FIFO.

Function
REQ-013 SHALL implement states IDLE and BUSY; a beat transfers when s_valid[i] and s_ready[i] are both high on a rising edge.
REQ-014 SHALL, in IDLE, hold s_ready = 2'b00, fifo_wr = 0 and grant = 2'b00.
REQ-015 SHALL, in IDLE with one s_valid bit high, register grant to that requester and enter BUSY on the next edge (one-cycle arbitration latency).
REQ-016 SHALL, in IDLE with both s_valid bits high, grant the requester other than last_owner (round-robin).
REQ-017 SHALL, in BUSY, drive s_ready[g] = ~fifo_full for granted requester g and s_ready of the other requester = 0, combinationally.
REQ-018 SHALL drive fifo_wr = s_valid[g] & ~fifo_full and fifo_wdata = data of requester g in BUSY; fifo_wdata = 0 in IDLE.
REQ-019 SHALL never assert fifo_wr while fifo_full is high; a stalled beat stays pending with no loss or duplication.
REQ-020 SHALL keep the grant across cycles where s_valid[g] is low (gap inside a message).
REQ-021 SHALL, on a transfer with s_last[g] high, return to IDLE, set last_owner = g, clear grant on the next edge.
REQ-022 SHALL keep a beat counter of width $clog2(MAX_BURST+1), cleared on grant, incremented per transfer, saturating at MAX_BURST.
REQ-023 SHALL deliver beats of one grant to the FIFO in requester order with no interleaving of the other requester.

Reset
REQ-024 SHALL, on reset, force state IDLE, grant 2'b00, beat counter 0, last_owner = 1 (requester 0 wins first tie).
REQ-025 SHALL, on reset asserted mid-message, deassert fifo_wr and s_ready immediately and discard the partial grant.

Configuration
REQ-026 SHALL, with UART_ARB_BURST_LIMIT_EN defined, also end a grant (as REQ-021) on the transfer that makes the beat count reach MAX_BURST, even without s_last.
REQ-027 SHALL, without UART_ARB_BURST_LIMIT_EN, end a grant only on s_last; the counter still counts but never releases the grant.

Structure
REQ-028 SHALL place the state enumeration (IDLE, BUSY) and the requester count constant (2) in package uart_pkg.
REQ-029 SHALL be a single module with no sub-module; the TX FIFO is instantiated by the parent and connected via fifo_full/fifo_wr/fifo_wdata.

Verification
REQ-030 SHALL cover: requester 0 sends 0x41,0x42(last), fifo_full=0 -> grant=01 one cycle after valid, fifo_wr two cycles, data 0x41 then 0x42, then grant=00.
REQ-031 SHALL cover: both requesters valid from reset -> requester 0 message first, then requester 1, then requester 0 again on next tie.
REQ-032 SHALL cover: fifo_full high for 3 cycles mid-message -> s_ready and fifo_wr low for those 3 cycles, held beat written once after release.
REQ-033 SHALL cover: with UART_ARB_BURST_LIMIT_EN, MAX_BURST=4, requester 0 streams 6 beats, requester 1 valid -> 4 beats of 0, then requester 1 message, then remaining 2 beats of 0.
REQ-034 SHALL cover: reset asserted after 2 of 5 beats -> fifo_wr low in same cycle, grant=00, next arbitration grants requester 0 on a tie.
